// File: rtl/microwave_fnd_alarm.sv
`default_nettype none
// ============================================================================
// Module   : microwave_fnd_alarm
// Purpose  : 4-digit multiplexed FND driver, buzzer alarm sequencer and
//            FINISH acknowledge for the microwave controller.
// Options  : FND_BLINK_EN - blank the display on alternate BLINK_CYC periods
//            while in SETTING with i_run low.
// Revision : 1.0 - initial release
// ============================================================================
module microwave_fnd_alarm #(
  parameter int SCAN_DIV     = 100000,
  parameter int TONE_HALF    = 25000,
  parameter int BEEP_ON_CYC  = 30000000,
  parameter int BEEP_OFF_CYC = 20000000,
  parameter int BEEP_COUNT   = 3,
  parameter int BLINK_CYC    = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] i_sec,
  input  logic        i_run,
  input  logic [3:0]  i_state,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data,
  output logic        o_buzzer,
  output logic        o_finish
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int CYC_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [CYC_W-1:0]  ON_LAST   = CYC_W'(BEEP_ON_CYC - 1);
  localparam logic [CYC_W-1:0]  OFF_LAST  = CYC_W'(BEEP_OFF_CYC - 1);
  localparam logic [3:0]        BEEPS     = 4'(BEEP_COUNT);

  typedef enum logic [2:0] {
    A_IDLE = 3'd0,
    A_ON   = 3'd1,
    A_OFF  = 3'd2,
    A_DONE = 3'd3,
    A_WAIT = 3'd4
  } alarm_e;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // ---------------------------------------------------------------- digits
  logic [3:0][3:0] digits_d, digits_q;
  logic [10:0]     sec_div10, sec_div100;

  always_comb begin
    sec_div10   = i_sec / 11'd10;
    sec_div100  = i_sec / 11'd100;
    digits_d[0] = 4'(i_sec % 11'd10);
    digits_d[1] = 4'(sec_div10 % 11'd10);
    digits_d[2] = 4'(sec_div100 % 11'd10);
    digits_d[3] = 4'(i_sec / 11'd1000);
  end

  always_ff @(posedge clk) begin
    digits_q <= digits_d;
  end

  // ------------------------------------------------------------------ blink
  logic blank_force;

`ifdef FND_BLINK_EN
  localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  logic               setting_d, setting_q;
  logic [BLINK_W-1:0] blink_cnt_d, blink_cnt_q;
  logic               blink_ph_d, blink_ph_q;

  always_comb begin
    setting_d   = i_state[1];
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    // Restart on SETTING entry so the first period is always visible.
    if (i_state[1] && !setting_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (i_state[1]) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    blank_force = i_state[1] & setting_q & ~i_run & blink_ph_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      setting_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      setting_q   <= setting_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_CYC > 0) & i_run;
  assign blank_force  = 1'b0;
`endif

  // ------------------------------------------------------------------- scan
  logic [SCAN_W-1:0] scan_cnt_d, scan_cnt_q;
  logic [1:0]        digit_idx_d, digit_idx_q;
  logic [3:0]        fnd_com_d, fnd_com_q;
  logic [7:0]        fnd_data_d, fnd_data_q;
  logic [3:0]        digit_sel;

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end

    digit_sel = digits_q[digit_idx_q];
    fnd_com_d = ~(4'b0001 << digit_idx_q);

    case (i_state)
      4'b0001:          fnd_data_d = 8'hC0;
      4'b0010, 4'b0100: fnd_data_d = seg7(digit_sel);
      4'b1000: begin
        case (digit_idx_q)
          2'd3:    fnd_data_d = 8'hFF;
          2'd2:    fnd_data_d = 8'h86;
          2'd1:    fnd_data_d = 8'hAB;
          default: fnd_data_d = 8'hA1;
        endcase
      end
      default:          fnd_data_d = 8'hFF;
    endcase
    if (blank_force) fnd_data_d = 8'hFF;
  end

  // ------------------------------------------------------------------ alarm
  alarm_e            state_d, state_q;
  logic [3:0]        beep_d, beep_q;
  logic [CYC_W-1:0]  cyc_d, cyc_q;
  logic [TONE_W-1:0] tone_cnt_d, tone_cnt_q;
  logic              tone_ph_d, tone_ph_q;
  logic              fin_q, fin_rise;
  logic              buzzer_d, buzzer_q;
  logic              finish_d, finish_q;

  assign fin_rise = i_state[3] & ~fin_q;

  always_comb begin
    state_d    = state_q;
    beep_d     = beep_q;
    cyc_d      = cyc_q;
    tone_cnt_d = tone_cnt_q;
    tone_ph_d  = tone_ph_q;

    case (state_q)
      A_IDLE: begin
        if (fin_rise) begin
          state_d    = A_ON;
          beep_d     = 4'd1;
          cyc_d      = '0;
          tone_cnt_d = '0;
          tone_ph_d  = 1'b0;
        end
      end
      A_ON: begin
        if (!i_state[3]) begin
          state_d = A_IDLE;
        end else if (cyc_q == ON_LAST) begin
          cyc_d   = '0;
          state_d = (beep_q == BEEPS) ? A_DONE : A_OFF;
        end else begin
          cyc_d = cyc_q + 1'b1;
          if (tone_cnt_q == TONE_LAST) begin
            tone_cnt_d = '0;
            tone_ph_d  = ~tone_ph_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
          end
        end
      end
      A_OFF: begin
        if (!i_state[3]) begin
          state_d = A_IDLE;
        end else if (cyc_q == OFF_LAST) begin
          cyc_d      = '0;
          beep_d     = beep_q + 4'd1;
          state_d    = A_ON;
          tone_cnt_d = '0;
          tone_ph_d  = 1'b0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      A_DONE:  state_d = A_WAIT;
      A_WAIT:  if (!i_state[3]) state_d = A_IDLE;
      default: state_d = A_IDLE;
    endcase

    // Gating with i_state[3] silences the buzzer on the same edge an abort is seen.
    buzzer_d = (state_q == A_ON) & i_state[3] & ~tone_ph_q;
    finish_d = (state_q == A_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      fnd_com_q   <= 4'b1111;
      fnd_data_q  <= 8'hFF;
      state_q     <= A_IDLE;
      beep_q      <= 4'd0;
      cyc_q       <= '0;
      tone_cnt_q  <= '0;
      tone_ph_q   <= 1'b0;
      fin_q       <= 1'b0;
      buzzer_q    <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      fnd_com_q   <= fnd_com_d;
      fnd_data_q  <= fnd_data_d;
      state_q     <= state_d;
      beep_q      <= beep_d;
      cyc_q       <= cyc_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_ph_q   <= tone_ph_d;
      fin_q       <= i_state[3];
      buzzer_q    <= buzzer_d;
      finish_q    <= finish_d;
    end
  end

  assign fnd_com  = fnd_com_q;
  assign fnd_data = fnd_data_q;
  assign o_buzzer = buzzer_q;
  assign o_finish = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_microwave_fnd_alarm.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_fnd_alarm
// Purpose  : Self-checking bench for microwave_fnd_alarm with randomized
//            display stimulus and an arithmetic alarm timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microwave_fnd_alarm;

  localparam int SCAN_DIV     = 4;
  localparam int TONE_HALF    = 2;
  localparam int BEEP_ON_CYC  = 20;
  localparam int BEEP_OFF_CYC = 10;
  localparam int BEEP_COUNT   = 3;
  localparam int BLINK_CYC    = 16;
  localparam int FINISH_AT    = BEEP_COUNT * BEEP_ON_CYC + (BEEP_COUNT - 1) * BEEP_OFF_CYC + 1;

  localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic        clk;
  logic        reset;
  logic [10:0] i_sec;
  logic        i_run;
  logic [3:0]  i_state;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        o_buzzer;
  logic        o_finish;

  int n_checks;
  int n_errors;
  int edges;

  microwave_fnd_alarm #(
    .SCAN_DIV    (SCAN_DIV),
    .TONE_HALF   (TONE_HALF),
    .BEEP_ON_CYC (BEEP_ON_CYC),
    .BEEP_OFF_CYC(BEEP_OFF_CYC),
    .BEEP_COUNT  (BEEP_COUNT),
    .BLINK_CYC   (BLINK_CYC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_sec   (i_sec),
    .i_run   (i_run),
    .i_state (i_state),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data),
    .o_buzzer(o_buzzer),
    .o_finish(o_finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; drives the expected scan position.
  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 1000000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_data(input int idx, input logic [3:0] st, input int sec);
    int p;
    p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
    case (st)
      4'b0001:          return 8'hC0;
      4'b0010, 4'b0100: return GLYPH[(sec / p) % 10];
      4'b1000:          return (idx == 3) ? 8'hFF : (idx == 2) ? 8'h86 : (idx == 1) ? 8'hAB : 8'hA1;
      default:          return 8'hFF;
    endcase
  endfunction

  // k = edges since the edge that first sampled FINISH high (k=0 is that edge).
  function automatic logic exp_buzz(input int k);
    int c, s;
    if (k < 1) return 1'b0;
    c = k - 1;
    for (int j = 0; j < BEEP_COUNT; j++) begin
      s = j * (BEEP_ON_CYC + BEEP_OFF_CYC);
      if (c >= s && c < s + BEEP_ON_CYC) return (((c - s) / TONE_HALF) % 2) == 0;
    end
    return 1'b0;
  endfunction

  task automatic tick(input bit chk_data, input bit blank);
    int         idx;
    logic [3:0] com_exp;
    @(negedge clk);
    if (reset) begin
      check("rst_com", fnd_com, 4'b1111);
      check("rst_data", fnd_data, 8'hFF);
      check("rst_buzz", o_buzzer, 1'b0);
      check("rst_fin", o_finish, 1'b0);
    end else begin
      idx     = ((edges - 1) / SCAN_DIV) % 4;
      com_exp = ~(4'b0001 << idx);
      check("com", fnd_com, com_exp);
      if (chk_data)
        check("data", fnd_data, blank ? 8'hFF : exp_data(idx, i_state, int'(i_sec)));
    end
  endtask

  task automatic drive(input logic [3:0] st, input int sec, input logic run, input int hold);
    i_state = st;
    i_sec   = 11'(sec);
    i_run   = run;
    for (int h = 0; h < hold; h++) tick(h >= 1, 1'b0);
  endtask

  task automatic run_alarm(input int abort_at, input int total);
    int last_chg;
    logic eb, ef;
    last_chg = -1;
    i_state  = 4'b1000;
    i_sec    = 11'($urandom_range(0, 2047));
    for (int k = 0; k < total; k++) begin
      tick((k - last_chg) >= 2, 1'b0);
      eb = (abort_at >= 0 && k > abort_at) ? 1'b0 : exp_buzz(k);
      ef = (abort_at >= 0 && k > abort_at) ? 1'b0 : (k == FINISH_AT);
      check("buzzer", o_buzzer, eb);
      check("finish", o_finish, ef);
      if (k == abort_at) begin
        i_state  = 4'b0001;
        last_chg = k;
      end
    end
  endtask

  task automatic reset_mid_alarm();
    i_state = 4'b1000;
    for (int k = 0; k < 40; k++) begin
      tick(k >= 1, 1'b0);
      check("pre_rst_buzz", o_buzzer, exp_buzz(k));
    end
    reset   = 1'b1;
    i_state = 4'b0001;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick(1'b1, 1'b0);
      check("post_rst_buzz", o_buzzer, 1'b0);
      check("post_rst_fin", o_finish, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] st;
    logic       run;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    i_state  = 4'b0001;
    i_sec    = 11'd0;
    i_run    = 1'b0;

    repeat (3) tick(1'b0, 1'b0);
    reset = 1'b0;
    for (int h = 0; h < 8; h++) tick(1'b1, 1'b0);

    drive(4'b0010, 1234, 1'b0, 16);
    drive(4'b0100, 10, 1'b1, 8);
    drive(4'b0100, 9, 1'b1, 8);

    drive(4'b0001, 0, 1'b0, 4);
    run_alarm(-1, 160);
    drive(4'b0001, 0, 1'b0, 4);
    run_alarm(25, 120);
    drive(4'b0001, 0, 1'b0, 4);
    run_alarm(-1, 100);
    drive(4'b0001, 0, 1'b0, 4);
    reset_mid_alarm();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       st = 4'b0001;
        1:       st = 4'b0010;
        2:       st = 4'b0100;
        3:       st = 4'b1000;
        default: st = 4'($urandom_range(0, 15));
      endcase
`ifdef FND_BLINK_EN
      run = 1'b1;
`else
      run = 1'($urandom_range(0, 1));
`endif
      drive(st, int'($urandom_range(0, 2047)), run, int'($urandom_range(3, 12)));
    end

`ifdef FND_BLINK_EN
    drive(4'b0001, 50, 1'b0, 4);
    i_state = 4'b0010;
    for (int k = 0; k < 64; k++)
      tick(1'b1, (k >= 1) && (((k - 1) / BLINK_CYC) % 2 == 1));
`else
    drive(4'b0001, 50, 1'b0, 4);
    drive(4'b0010, 50, 1'b0, 64);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microwave_fnd_alarm.md
Name: microwave_fnd_alarm

Overview:
- Output-side companion of the microwave controller FSM.
- Consumes the controller's remaining-seconds value, run flag and one-hot state.
- Drives a 4-digit multiplexed FND and a buzzer, and generates the `finish` acknowledge that releases the controller from FINISH back to IDLE.
- Sits between the controller and the board FND/buzzer pins.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays selected before the scan advances.
- TONE_HALF, 25000: cycles per half-period of the buzzer square wave.
- BEEP_ON_CYC, 30000000: length of one beep in cycles.
- BEEP_OFF_CYC, 20000000: gap between beeps in cycles.
- BEEP_COUNT, 3: number of beeps per alarm, range 1..15.
- BLINK_CYC, 50000000: blink half-period in cycles. Used only with FND_BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_sec  in  11  remaining seconds, unsigned, 0..2047.
- i_run  in  1  controller run flag.
- i_state  in  4  one-hot controller state: [3] FINISH, [2] RUN, [1] SETTING, [0] IDLE.
- fnd_com  out  4  digit enables, active-low. [0] is the ones digit.
- fnd_data  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- o_buzzer  out  1  buzzer drive.
- o_finish  out  1  one-cycle acknowledge to the controller's `finish` input.

Behaviour:
- Reset (synchronous, active-high) forces:
  - fnd_com=4'b1111, fnd_data=8'hFF, o_buzzer=0, o_finish=0.
  - scan counter=0, digit index=0, alarm FSM=A_IDLE, edge register=0.
  - Reset asserted mid-alarm aborts the alarm immediately; no o_finish is issued.
- Digit decode:
  - i_sec is split into decimal digits d0..d3 (ones..thousands) and registered: 1-cycle latency from i_sec to the digit registers.
  - Glyphs 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90. Blank=FF, E=86, n=AB, d=A1.
- Display content by i_state:
  - IDLE: all four digits show 0 (C0).
  - SETTING/RUN: d3..d0.
  - FINISH: digit3 blank, digits2..0 = "End".
  - i_state not one-hot (including 0): all digits blank.
- Scan:
  - Counter runs 0..SCAN_DIV-1. At wrap, the digit index advances 0→1→2→3→0.
  - fnd_com is low only at bit[index]. fnd_data is the glyph for that index. Both are registered and change on the same edge.
  - The first digit drives on the cycle after reset deasserts.
- Alarm FSM, states A_IDLE, A_ON, A_OFF, A_DONE, A_WAIT:
  - fin_rise = i_state[3] & ~registered i_state[3].
  - A_IDLE: on fin_rise → A_ON; beep counter=1, cycle counter=0.
  - A_ON: o_buzzer toggles every TONE_HALF cycles, starting high. After BEEP_ON_CYC cycles: if beep counter==BEEP_COUNT → A_DONE, else → A_OFF.
  - A_OFF: o_buzzer=0. After BEEP_OFF_CYC cycles → A_ON, beep counter+1.
  - A_DONE: o_finish=1 for exactly one cycle, o_buzzer=0, then → A_WAIT.
  - A_WAIT: remain until i_state[3]==0, then → A_IDLE. No re-trigger while FINISH stays high.
  - In any of A_ON/A_OFF: if i_state[3] falls → A_IDLE; o_buzzer=0 next cycle; no o_finish.
  - o_finish is 0 in every state except A_DONE. o_buzzer is 0 in every state except A_ON.
  - i_run is not used for control. With FND_BLINK_EN it gates blinking.
- Alarm duration: BEEP_COUNT*BEEP_ON_CYC + (BEEP_COUNT-1)*BEEP_OFF_CYC cycles from entering A_ON to entering A_DONE.

Optional Feature:
- Macro: FND_BLINK_EN.
- Defined: when i_state[1] (SETTING) is high and i_run=0, all digits blank during alternate BLINK_CYC periods. The blink counter resets on entry to SETTING, so the first period is visible. fnd_com scanning continues unchanged; only fnd_data is forced to FF.
- Undefined: no blink logic; SETTING always shows d3..d0. BLINK_CYC is unused.

Test Plan (bench parameters: SCAN_DIV=4, TONE_HALF=2, BEEP_ON_CYC=20, BEEP_OFF_CYC=10, BEEP_COUNT=3, BLINK_CYC=16):
- Reset held 3 cycles with i_state=4'b0001 → all outputs at reset values. Next cycle fnd_com=1110 and fnd_data=C0; 4 cycles later fnd_com=1101.
- i_state=0010, i_sec=1234 → over one 16-cycle scan, fnd_data per digit is 99,B0,A4,F9 for com[0..3].
- i_state=0100, i_sec changes 10→9 → ones-digit glyph becomes 90 and tens-digit glyph becomes C0 from 1 cycle after the change.
- i_state moves 0100→1000 and is held → FND shows blank,"End". o_buzzer toggles every 2 cycles during three 20-cycle beeps separated by 10-cycle gaps. o_finish is a single-cycle pulse 81 cycles after the edge at which i_state[3] is first sampled high; then no further beeps while 1000 is held.
- FINISH entered, then i_state→0001 at cycle 25 (inside the gap) → o_buzzer stays 0 and o_finish never asserts. Re-entering FINISH restarts the full 3-beep sequence.
- FND_BLINK_EN defined, i_state=0010, i_run=0, i_sec=50 → fnd_data shows digits for 16 cycles, FF for 16 cycles, repeating. With the macro undefined, the digits never blank.
